pipelined_rca: RTL

- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry chunks with a registered carry between chunks, so long adders close timing.
- Valid/ready handshakes on input and output sustain one operation per clock.
- Reports carry-out and signed overflow.
- Used as the datapath adder in larger arithmetic blocks.

---
 rtl/pipelined_rca.sv | 95 +++++++++
 1 files changed

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// with a registered carry between chunks and valid/ready flow control on both sides.
module pipelined_rca #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   generate
      if (WIDTH % STAGES != 0) begin : g_bad_width
         $error("pipelined_rca: WIDTH must be divisible by STAGES");
      end
   endgenerate

   // Level 0 holds the captured operands; level k+1 holds the result after chunk k.
   logic [WIDTH-1:0] a_reg [STAGES+1];
   logic [WIDTH-1:0] b_reg [STAGES+1];
   logic [WIDTH-1:0] s_reg [STAGES+1];
   logic             c_reg [STAGES+1];
   logic             v_reg [STAGES+1];
   logic [CHUNK:0]   csum  [STAGES];
   logic             advance;
   logic             msb_cin;

   assign advance  = !v_reg[STAGES] || out_ready;
   assign in_ready = advance;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_reg[0] <= 1'b0;
         a_reg[0] <= '0;
         b_reg[0] <= '0;
         s_reg[0] <= '0;
         c_reg[0] <= 1'b0;
      end else if (advance) begin
         v_reg[0] <= in_valid;
         if (in_valid) begin
            a_reg[0] <= x;
            b_reg[0] <= sub ? ~y : y;
            s_reg[0] <= '0;
            c_reg[0] <= sub ? ~cin : cin;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int LO = gi * CHUNK;

         assign csum[gi] = {1'b0, a_reg[gi][LO +: CHUNK]}
                         + {1'b0, b_reg[gi][LO +: CHUNK]}
                         + (CHUNK+1)'(c_reg[gi]);

         // Bubbles travel with their (stale) data; only the valid bit matters downstream.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               v_reg[gi+1] <= 1'b0;
               a_reg[gi+1] <= '0;
               b_reg[gi+1] <= '0;
               s_reg[gi+1] <= '0;
               c_reg[gi+1] <= 1'b0;
            end else if (advance) begin
               v_reg[gi+1] <= v_reg[gi];
               a_reg[gi+1] <= a_reg[gi];
               b_reg[gi+1] <= b_reg[gi];
               s_reg[gi+1] <= s_reg[gi];
               s_reg[gi+1][LO +: CHUNK] <= csum[gi][CHUNK-1:0];
               c_reg[gi+1] <= csum[gi][CHUNK];
            end
         end
      end
   endgenerate

   // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
   assign msb_cin   = a_reg[STAGES][WIDTH-1] ^ b_reg[STAGES][WIDTH-1] ^ s_reg[STAGES][WIDTH-1];
   assign out_valid = v_reg[STAGES];
   assign sum       = s_reg[STAGES];
   assign cout      = c_reg[STAGES];
   assign ovf       = msb_cin ^ c_reg[STAGES];

endmodule
